clint_timer: RTL

- Core-local interrupt source; the generating end of the CSR file's `timer_int` and `sw_int` inputs.
- Holds a 64-bit free-running `mtime`, a 64-bit `mtimecmp`, and the `msip` bit.
- Firmware accesses these through a simple memory-mapped request/response port. The port sits on the data-memory bus decode, beside the W-stage CSR logic.
- `timer_int` is level (`mtime >= mtimecmp`). `sw_int` mirrors `msip[0]`.

---
 rtl/clint_pkg.sv | 30 +++
 rtl/clint_prescaler.sv | 29 ++
 rtl/clint_timer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/clint_pkg.sv
// clint_pkg: shared constants and types for the core-local interruptor.
// Default register offsets, reset values and bus decode encodings.
package clint_pkg;

  localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic {
    RESP_OK  = 1'b0,
    RESP_ERR = 1'b1
  } resp_err_e;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_MSIP,
    SEL_CMP_LO,
    SEL_CMP_HI,
    SEL_TIME_LO,
    SEL_TIME_HI
  } reg_sel_e;

  typedef enum logic {
    BUS_IDLE,
    BUS_RESP
  } bus_state_e;

endpackage

// File: rtl/clint_prescaler.sv
// clint_prescaler: divides clk by TICK_DIV.
// Emits a one-cycle tick every TICK_DIV cycles.
module clint_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  // Wrap the counter at TICK_DIV-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/clint_timer.sv
// clint_timer: mtime/mtimecmp/msip with a one-deep bus response slot.
// Drives the timer and software interrupt lines of the CSR file.
module clint_timer
  import clint_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int TICK_DIV = 1,
  parameter logic [ADDR_W-1:0] MSIP_OFF = ADDR_W'(CLINT_MSIP_OFF),
  parameter logic [ADDR_W-1:0] MTIMECMP_OFF = ADDR_W'(CLINT_MTIMECMP_OFF),
  parameter logic [ADDR_W-1:0] MTIME_OFF = ADDR_W'(CLINT_MTIME_OFF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              timer_int,
  output logic              sw_int
);

  localparam logic [ADDR_W-1:0] WMASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_MSIP = MSIP_OFF & WMASK;
  localparam logic [ADDR_W-1:0] A_CMPL = MTIMECMP_OFF & WMASK;
  localparam logic [ADDR_W-1:0] A_CMPH = (MTIMECMP_OFF + FOUR) & WMASK;
  localparam logic [ADDR_W-1:0] A_TIML = MTIME_OFF & WMASK;
  localparam logic [ADDR_W-1:0] A_TIMH = (MTIME_OFF + FOUR) & WMASK;

  logic [63:0]       mtime;
  logic [63:0]       mtimecmp;
  logic              msip;
  logic              tick;
  logic              accept;
  logic              wr;
  logic [ADDR_W-1:0] word;
  reg_sel_e          sel;
  logic [31:0]       rd_data;
  bus_state_e        state_q;
  bus_state_e        state_d;

  assign word       = req_addr & WMASK;
  assign resp_valid = (state_q == BUS_RESP);
  assign req_ready  = !resp_valid || resp_ready;
  assign accept     = req_valid && req_ready;
  assign wr         = accept && req_we;
  assign sw_int     = msip;

  clint_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_presc (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // Decode the word offset into a register select.
  always_comb begin
    sel = SEL_NONE;
    unique case (1'b1)
      (word == A_MSIP): sel = SEL_MSIP;
      (word == A_CMPL): sel = SEL_CMP_LO;
      (word == A_CMPH): sel = SEL_CMP_HI;
      (word == A_TIML): sel = SEL_TIME_LO;
      (word == A_TIMH): sel = SEL_TIME_HI;
      default:          sel = SEL_NONE;
    endcase
  end

  // Read mux over the pre-write register values.
  always_comb begin
    rd_data = '0;
    unique case (sel)
      SEL_MSIP:    rd_data = {31'b0, msip};
      SEL_CMP_LO:  rd_data = mtimecmp[31:0];
      SEL_CMP_HI:  rd_data = mtimecmp[63:32];
      SEL_TIME_LO: rd_data = mtime[31:0];
      SEL_TIME_HI: rd_data = mtime[63:32];
      default:     rd_data = '0;
    endcase
  end

  // Bus FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BUS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Response slot fills on accept, drains on resp_ready.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BUS_IDLE: if (accept) state_d = BUS_RESP;
      BUS_RESP: begin
        if (accept) begin
          state_d = BUS_RESP;
        end else if (resp_ready) begin
          state_d = BUS_IDLE;
        end
      end
    endcase
  end

  // Capture response data at accept; hold while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_rdata <= '0;
      resp_err   <= RESP_OK;
    end else if (accept) begin
      resp_rdata <= req_we ? 32'b0 : rd_data;
      resp_err   <= (sel == SEL_NONE) ? RESP_ERR : RESP_OK;
    end
  end

  // msip and mtimecmp software writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msip     <= 1'b0;
      mtimecmp <= MTIMECMP_RST;
    end else if (wr) begin
      if (sel == SEL_MSIP) msip <= req_wdata[0];
      if (sel == SEL_CMP_LO) mtimecmp[31:0] <= req_wdata;
      if (sel == SEL_CMP_HI) mtimecmp[63:32] <= req_wdata;
    end
  end

  // mtime: a software write beats the tick increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtime <= '0;
    end else if (wr && sel == SEL_TIME_LO) begin
      mtime <= {mtime[63:32], req_wdata};
    end else if (wr && sel == SEL_TIME_HI) begin
      mtime <= {req_wdata, mtime[31:0]};
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  // Level timer interrupt, registered compare.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_int <= 1'b0;
    end else begin
      timer_int <= (mtime >= mtimecmp);
    end
  end

endmodule
